// File: rtl/grid_checker_pkg.sv
// ============================================================================
// Module      : grid_checker_pkg
// Description : Shared constants, FSM encoding and cell addressing for the
//               grid checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package grid_checker_pkg;

  localparam int GRID_DIM = 9;
  localparam int CELLS    = GRID_DIM * GRID_DIM;
  localparam int CELL_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNAP   = 2'd1,
    ST_SCAN   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // LSB position of a linear cell index inside the flattened grid.
  function automatic logic [8:0] cell_offset(input logic [6:0] idx);
    return 9'(idx) * 9'(CELL_W);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sudoku_solution_rom.sv
// ============================================================================
// Module      : sudoku_solution_rom
// Description : Combinational lookup of the reference solution, row-major.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sudoku_solution_rom
  import grid_checker_pkg::*;
(
  input  logic [6:0] i_idx,
  output logic [3:0] o_digit
);

  localparam logic [3:0] c_SOL [0:CELLS-1] = '{
    4'd4, 4'd3, 4'd5, 4'd2, 4'd6, 4'd9, 4'd7, 4'd8, 4'd1,
    4'd6, 4'd8, 4'd2, 4'd5, 4'd7, 4'd1, 4'd4, 4'd9, 4'd3,
    4'd1, 4'd9, 4'd7, 4'd8, 4'd3, 4'd4, 4'd5, 4'd6, 4'd2,
    4'd8, 4'd2, 4'd6, 4'd1, 4'd9, 4'd5, 4'd3, 4'd4, 4'd7,
    4'd3, 4'd7, 4'd4, 4'd6, 4'd8, 4'd2, 4'd9, 4'd1, 4'd5,
    4'd9, 4'd5, 4'd1, 4'd7, 4'd4, 4'd3, 4'd6, 4'd2, 4'd8,
    4'd5, 4'd1, 4'd9, 4'd3, 4'd2, 4'd6, 4'd8, 4'd7, 4'd4,
    4'd2, 4'd4, 4'd8, 4'd9, 4'd5, 4'd7, 4'd1, 4'd3, 4'd6,
    4'd7, 4'd6, 4'd3, 4'd4, 4'd1, 4'd8, 4'd2, 4'd5, 4'd9
  };

  // Indices past the last cell read as 0, which never matches a valid digit.
  always_comb begin
    o_digit = 4'd0;
    if (i_idx < 7'(CELLS)) begin
      o_digit = c_SOL[i_idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/grid_checker.sv
// ============================================================================
// Module      : grid_checker
// Description : Snapshots a player grid and compares it cell-by-cell against
//               the stored solution, reporting fill and mismatch counts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_checker #(
  parameter int AUTO_RESCAN = 1,
  parameter int CELLS       = 81,
  parameter int CELL_W      = 4
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic [CELLS*CELL_W-1:0] flat_grid,
  input  logic                    start,
  output logic                    busy,
  output logic                    scan_done,
  output logic                    win_flag,
  output logic                    grid_full,
  output logic [6:0]              filled_cnt,
  output logic [6:0]              mismatch_cnt
);

  import grid_checker_pkg::*;

  localparam logic [6:0] c_LAST_IDX = 7'(CELLS - 1);
  localparam logic [6:0] c_FULL_CNT = 7'(CELLS);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CELLS*CELL_W-1:0] r_snap;
  logic [6:0]              r_idx;
  logic [6:0]              r_filled;
  logic [6:0]              r_miss;
  logic                    r_done;
  logic                    r_win;
  logic                    r_full;
  logic [6:0]              r_filled_out;
  logic [6:0]              r_miss_out;

  logic [CELL_W-1:0]       w_cell;
  logic [3:0]              w_sol;
  logic                    w_is_filled;
  logic                    w_is_miss;

  sudoku_solution_rom u_rom (
    .i_idx   (r_idx),
    .o_digit (w_sol)
  );

  assign w_cell      = r_snap[cell_offset(r_idx) +: CELL_W];
  assign w_is_filled = (w_cell != '0);
  assign w_is_miss   = (w_cell != CELL_W'(w_sol));

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if ((AUTO_RESCAN != 0) || start) w_state_nxt = ST_SNAP;
      ST_SNAP:   w_state_nxt = ST_SCAN;
      ST_SCAN:   if (r_idx == c_LAST_IDX) w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = (AUTO_RESCAN != 0) ? ST_SNAP : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Results are only published in UPDATE, so an aborted scan leaves no trace.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_snap       <= '0;
      r_idx        <= '0;
      r_filled     <= '0;
      r_miss       <= '0;
      r_done       <= 1'b0;
      r_win        <= 1'b0;
      r_full       <= 1'b0;
      r_filled_out <= '0;
      r_miss_out   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_SNAP: begin
          r_snap   <= flat_grid;
          r_idx    <= '0;
          r_filled <= '0;
          r_miss   <= '0;
        end
        ST_SCAN: begin
          r_idx    <= r_idx + 7'd1;
          r_filled <= r_filled + 7'(w_is_filled);
          r_miss   <= r_miss + 7'(w_is_miss);
        end
        ST_UPDATE: begin
          r_filled_out <= r_filled;
          r_miss_out   <= r_miss;
          r_win        <= (r_miss == 7'd0);
          r_full       <= (r_filled == c_FULL_CNT);
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign scan_done    = r_done;
  assign win_flag     = r_win;
  assign grid_full    = r_full;
  assign filled_cnt   = r_filled_out;
  assign mismatch_cnt = r_miss_out;

endmodule

`default_nettype wire

// File: doc/grid_checker.md
GRID_CHECKER -- requirements
Module: grid_checker

Interface
REQ-001 The block SHALL have parameter AUTO_RESCAN, default 1; 1 means it rescans continuously, 0 means it scans only on start.
REQ-002 The block SHALL have parameter CELLS, default 81; this is the number of grid cells.
REQ-003 The block SHALL have parameter CELL_W, default 4; this is the bits per cell.
REQ-004 Port clk, input, 1 bit: master clock. One clock; all logic SHALL be on its rising edge.
REQ-005 Port clr_n, input, 1 bit: reset. Reset is synchronous and active-low.
REQ-006 Port flat_grid, input, 324 bits: player grid. Cell (r,c) SHALL sit at bits [(r*9+c)*4 +: 4]; value 0 means empty.
REQ-007 Port start, input, 1 bit: scan request pulse. It is ignored when AUTO_RESCAN=1.
REQ-008 Port busy, output, 1 bit: high from snapshot through update.
REQ-009 Port scan_done, output, 1 bit: one-cycle pulse when results update.
REQ-010 Port win_flag, output, 1 bit: last completed scan matched the solution in all 81 cells.
REQ-011 Port grid_full, output, 1 bit: last completed scan found no zero cell.
REQ-012 Port filled_cnt, output, 7 bits: non-zero cells in the last scan.
REQ-013 Port mismatch_cnt, output, 7 bits: cells differing from the solution in the last scan.

Function
REQ-014 The FSM SHALL have states IDLE, SNAP, SCAN and UPDATE, encoded 2 bits.
REQ-015 IDLE SHALL go to SNAP when start=1 (AUTO_RESCAN=0), or unconditionally (AUTO_RESCAN=1).
REQ-016 SNAP SHALL copy flat_grid into a 324-bit snapshot register, clear the index and both accumulators, and go to SCAN.
REQ-017 SCAN SHALL examine one cell per cycle at index 0..80; at index 80 it SHALL go to UPDATE.
REQ-018 Per cell, when value != 0 the filled accumulator SHALL increment.
REQ-019 Per cell, when value != solution(index) the mismatch accumulator SHALL increment; this includes empty cells and values 10-15.
REQ-020 Accumulators SHALL be 7 bits wide; the maximum count is 81, so no saturation logic is needed.
REQ-021 UPDATE SHALL register the count outputs, set win_flag = (mismatch==0), set grid_full = (filled==81), and pulse scan_done for 1 cycle.
REQ-022 After UPDATE the FSM SHALL return to IDLE (AUTO_RESCAN=0) or go directly to SNAP (AUTO_RESCAN=1).
REQ-023 Latency SHALL be fixed: scan_done occurs 83 cycles after the SNAP cycle (1 SNAP + 81 SCAN + 1 UPDATE).
REQ-024 A start pulse while busy=1 SHALL be dropped and SHALL NOT be queued.
REQ-025 Changes to flat_grid during a scan SHALL NOT affect the result in progress; the snapshot is the only data source.
REQ-026 Outputs SHALL hold their values between UPDATE cycles; they change only in UPDATE or reset.
REQ-027 busy SHALL be 1 in SNAP, SCAN and UPDATE, and 0 in IDLE.
REQ-028 Win is recomputed on every scan and is not sticky; clearing a cell drops win_flag at the next UPDATE.

Reset
REQ-029 While clr_n=0 at a clock edge, the state SHALL become IDLE.
REQ-030 Under reset, index, accumulators and snapshot SHALL become 0.
REQ-031 Under reset, outputs SHALL be busy=0, scan_done=0, win_flag=0, grid_full=0, filled_cnt=0 and mismatch_cnt=0.
REQ-032 A reset mid-scan SHALL abort the scan with no scan_done pulse and no partial results on the outputs.

Structure
REQ-033 A shared package SHALL hold GRID_DIM=9, CELLS=81, CELL_W=4, the FSM state encoding, and the cell-offset function.
REQ-034 The solution SHALL come from one sub-module, sudoku_solution_rom: 7-bit index in, 4-bit digit out, combinational, 81 entries.
REQ-035 The row-0 contents of sudoku_solution_rom SHALL be 4,3,5,2,6,9,7,8,1 and the row-8 contents 7,6,3,4,1,8,2,5,9.
REQ-036 No other sub-modules SHALL be used.

Verification
REQ-037 Stimulus: reset, AUTO_RESCAN=0, flat_grid all zero, start pulse -> busy for 83 cycles, then scan_done with filled_cnt=0, mismatch_cnt=81, win_flag=0, grid_full=0.
REQ-038 Stimulus: flat_grid = full solution, start -> scan_done with filled_cnt=81, mismatch_cnt=0, win_flag=1, grid_full=1.
REQ-039 Stimulus: solution with cell (4,4) set to 7 -> filled_cnt=81, mismatch_cnt=1, win_flag=0, grid_full=1.
REQ-040 Stimulus: start a solved-grid scan, zero cell (0,0) at scan cycle 10, send a second start at cycle 20 -> first result win_flag=1; the second start is dropped, no second scan_done.
REQ-041 Stimulus: clr_n low for 1 cycle at scan cycle 40 -> busy=0 the next cycle, all outputs 0, no scan_done.
REQ-042 Stimulus: AUTO_RESCAN=1 with the solved grid -> scan_done pulses exactly every 83 cycles and win_flag stays 1.
